generic_sdp_ram_init: RTL
=========================

// Module: generic_sdp_ram_init
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port.
//  Adds a selectable read latency with rd_valid, a selectable read-during-write mode, and a
//  power-up clear sequencer that sweeps every word to INIT_VALUE. Serves as the frame/line buffer
//  between the SD-card loader (write side) and the image-processing and VGA pipeline (read side).
// PARAMETERS
//  DATA_WIDTH     16   word width; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH     15   address width; DEPTH = 1<<ADDR_WIDTH
//  BYTE_WIDTH     8    lane width for wr_be; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
//  RD_LATENCY     1    1 or 2 cycles from accepted rd_en to rd_valid/rd_data
//  RDW_MODE       0    0 = read-old-data, 1 = write-first on a same-address collision
//  INIT_ON_RESET  1    1 = clear sweep after reset; 0 = ready immediately, contents undefined
//  INIT_VALUE     0    DATA_WIDTH-wide value written by the sweep
// PORTS
//  clk       in   1           single clock; all logic on posedge
//  rst_n     in   1           asynchronous, active-low reset
//  wr_en     in   1           write request
//  wr_addr   in   ADDR_WIDTH  write address
//  wr_data   in   DATA_WIDTH  write data
//  wr_be     in   NUM_BYTES   per-lane write enable; lane i = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//  rd_en     in   1           read request
//  rd_addr   in   ADDR_WIDTH  read address
//  rd_data   out  DATA_WIDTH  read data; holds its last value between reads
//  rd_valid  out  1           one-cycle pulse marking rd_data valid
//  ready     out  1           high once the init sweep is done; requests are ignored while low
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//  - Reset values: rd_data=0, rd_valid=0, read pipeline flushed, sweep counter=0,
//    ready = !INIT_ON_RESET. rst_n does not clear the storage array (keeps BRAM inference).
//  - FSM states INIT and RUN. Reset enters INIT if INIT_ON_RESET, else RUN.
//  - INIT: writes INIT_VALUE to address cnt and increments cnt every cycle, for DEPTH cycles.
//    After the write to DEPTH-1, moves to RUN; ready rises the next cycle (DEPTH cycles after
//    reset release).
//  - In INIT: wr_en and rd_en are ignored and rd_valid stays 0. rst_n asserted mid-sweep
//    restarts the sweep from address 0.
//  - RUN, write: when wr_en=1, lane i of mem[wr_addr] is updated only if wr_be[i]=1.
//    wr_be=0 leaves the word unchanged.
//  - RUN, read: rd_en accepted every cycle; fully pipelined, throughput 1 read/cycle.
//    RD_LATENCY=1: data and valid after the next edge. RD_LATENCY=2: one extra output register,
//    and valid is delayed to match.
//  - Collision (wr_en & rd_en & wr_addr==rd_addr, same cycle):
//    RDW_MODE=0 returns the pre-write word.
//    RDW_MODE=1 returns the merged word: wr_data lanes where wr_be=1, old lanes elsewhere.
//    Implemented with a registered bypass (collision flag, wr_data, wr_be) muxed at the read
//    register.
//  - Read and write at different addresses in the same cycle are independent.
//  - Address arithmetic: the sweep counter is ADDR_WIDTH+1 bits so it can detect terminal count.
//    Port addresses are used as given; they cannot go out of range.
// STRUCTURE
//  - generic_ram_defs.vh holds the localparams RDW_READ_OLD=0, RDW_WRITE_FIRST=1 and the
//    NUM_BYTES derivation, shared with the other buffers.
//  - Sub-module sdp_ram_array: storage plus byte-lane write and registered read, no reset.
//    The top level holds the init FSM, the write-port mux (sweep vs user), the collision bypass,
//    the latency pipeline and rd_valid.
// TESTING
//  1. Use ADDR_WIDTH=4, INIT_VALUE=16'hA5A5. Release reset -> ready rises exactly 16 cycles
//     later; reading addresses 0..15 returns 16'hA5A5.
//  2. During INIT, drive wr_en with addr 3, data 16'h1234 and rd_en -> rd_valid stays 0;
//     after ready, addr 3 reads 16'hA5A5.
//  3. Write 16'hBEEF to addr 5, then write 16'h12CD with wr_be=2'b01 -> reading addr 5
//     returns 16'hBECD.
//  4. Set mem[7]=16'h0000. In the same cycle, write 16'hFFFF with be=2'b10 and read addr 7 ->
//     RDW_MODE=0 returns 16'h0000; RDW_MODE=1 returns 16'hFF00.
//  5. RD_LATENCY=2, back-to-back reads of addresses 0,1,2 -> rd_valid is high on cycles
//     t+2..t+4 with data in order; rd_data holds the addr-2 data afterwards.
//  6. Assert rst_n at sweep count 8, then release -> ready rises 16 cycles after release and
//     all words read INIT_VALUE.

Source files
------------

// File: rtl/generic_sdp_ram_init_pkg.sv
// Shared definitions for the generic simple-dual-port RAM family.
//  - Read-during-write mode encodings used by the buffers.
//  - Init/run state type for the clear sequencer.
//  - Byte-lane count derivation from word and lane widths.
package generic_sdp_ram_init_pkg;

    localparam int RDW_READ_OLD    = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // DATA_WIDTH must be an integer multiple of BYTE_WIDTH.
    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/generic_sdp_ram_init_array.sv
// Storage core for generic_sdp_ram_init: one write port with byte-lane
// enables and one registered read port. No reset, so the array maps onto
// block RAM.
// Ports:
//  clk    in   clock, all logic on posedge
//  we     in   write enable
//  waddr  in   write address
//  wdata  in   write data
//  wbe    in   per-lane write enable
//  re     in   read enable; rdata updates only when set
//  raddr  in   read address
//  rdata  out  registered read data (old data on a same-address write)
module generic_sdp_ram_init_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_BYTES  = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NUM_BYTES-1:0]  wbe,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/generic_sdp_ram_init.sv
// Simple-dual-port RAM with byte enables, selectable read latency (1 or 2),
// selectable read-during-write behaviour and a power-up clear sweep.
// Ports:
//  clk       in   clock
//  rst_n     in   asynchronous active-low reset (storage is not cleared by it)
//  wr_en     in   write request
//  wr_addr   in   write address
//  wr_data   in   write data
//  wr_be     in   per-lane write enable
//  rd_en     in   read request
//  rd_addr   in   read address
//  rd_data   out  read data, holds between reads
//  rd_valid  out  one-cycle pulse marking rd_data valid
//  ready     out  high once the clear sweep is finished
module generic_sdp_ram_init
    import generic_sdp_ram_init_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 15,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    RD_LATENCY    = 1,
    parameter int                    RDW_MODE      = 0,
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
    input  logic                               rd_en,
    input  logic [ADDR_WIDTH-1:0]              rd_addr,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    output logic                               ready
);

    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    // ------------------------------------------------------------------
    // Init / run sequencer
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 run;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            // Extra counter bit sets right after the write to DEPTH-1.
            if (cnt_d[ADDR_WIDTH]) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            ready_q <= (INIT_ON_RESET == 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Write-port mux: sweep owns the port during INIT
    // ------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_BYTES-1:0]  mem_wbe;
    logic                  rd_accept;

    always_comb begin
        mem_we    = wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = INIT_VALUE;
            mem_wbe   = '1;
        end
    end

    assign rd_accept = rd_en && run;

    logic [DATA_WIDTH-1:0] arr_rdata;

    generic_sdp_ram_init_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_BYTES  (NUM_BYTES)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_wbe),
        .re    (rd_accept),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    // ------------------------------------------------------------------
    // Collision bypass and first read stage. The bypass registers load
    // only on an accepted read so the merged word keeps being presented
    // while the array read register holds.
    // ------------------------------------------------------------------
    logic                  coll_q, coll_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [NUM_BYTES-1:0]  byp_be_q, byp_be_d;
    logic                  has_data_q, has_data_d;
    logic                  v1_q, v1_d;

    always_comb begin
        coll_d     = coll_q;
        byp_data_d = byp_data_q;
        byp_be_d   = byp_be_q;
        has_data_d = has_data_q;
        v1_d       = rd_accept;
        if (rd_accept) begin
            coll_d     = (RDW_MODE == RDW_WRITE_FIRST) && wr_en && (wr_addr == rd_addr);
            byp_data_d = wr_data;
            byp_be_d   = wr_be;
            has_data_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q     <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
            has_data_q <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            coll_q     <= coll_d;
            byp_data_q <= byp_data_d;
            byp_be_q   <= byp_be_d;
            has_data_q <= has_data_d;
            v1_q       <= v1_d;
        end
    end

    logic [DATA_WIDTH-1:0] s1_word;
    logic [DATA_WIDTH-1:0] s1_data;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign s1_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                (coll_q && byp_be_q[gi]) ? byp_data_q[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                         : arr_rdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // The array register has no reset; present zero until the first read.
    assign s1_data = has_data_q ? s1_word : '0;

    // ------------------------------------------------------------------
    // Output latency
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  v2_q, v2_d;

            always_comb begin
                rd_data_d = rd_data_q;
                v2_d      = v1_q;
                if (v1_q) begin
                    rd_data_d = s1_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                    v2_q      <= 1'b0;
                end else begin
                    rd_data_q <= rd_data_d;
                    v2_q      <= v2_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = v2_q;
        end else begin : g_lat1
            assign rd_data  = s1_data;
            assign rd_valid = v1_q;
        end
    endgenerate

endmodule
